mem_access_seq: RTL and testbench
=================================

# mem_access_seq

Parametrised, sequenced memory-access stage for the pipeline. It performs single loads and stores (LW/SW) and multi-register bursts (LM/SM) against an internal word-addressed data memory. A small FSM walks a register mask one transfer per cycle, auto-incrementing the address. It sits between the execute stage (base/ALU address) and register writeback, and holds the pipeline via `busy` while a burst runs.

## Interface
- `DATA_W`, default 16: data word width.
- `ADDR_W`, default 16: address width; address arithmetic wraps modulo 2^ADDR_W.
- `DEPTH`, default 256: memory words (power of two); memory index = address mod DEPTH.
- `NREG`, default 8: register-mask width; `IDX_W` = clog2(NREG).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; accepted only when `busy`=0.
- `op` in 2: 00 LW, 01 SW, 10 LM, 11 SM; sampled at acceptance.
- `base_addr` in ADDR_W: address from pipeline register.
- `alu_out` in ADDR_W: address from ALU.
- `addr_sel` in 1: 0 selects `base_addr`, 1 selects `alu_out`; sampled at acceptance.
- `reg_mask` in NREG: LM/SM register set; sampled at acceptance.
- `dest_idx` in IDX_W: LW destination register; sampled at acceptance.
- `store_data` in DATA_W: SW data (sampled at acceptance); SM data (combinational, same cycle as `reg_rd_idx`).
- `reg_rd_idx` out IDX_W: register to read for the current SM transfer.
- `wb_valid` out 1: register writeback strobe.
- `wb_idx` out IDX_W: writeback register index.
- `wb_data` out DATA_W: writeback data.
- `busy` out 1: FSM not IDLE; pipeline must stall.
- `done` out 1: one-cycle pulse on the last EXEC cycle.
- `next_addr` out ADDR_W: registered last-used address + 1, for base update.

## Operation
- States: IDLE, EXEC.
- IDLE → EXEC on `start`. Capture:
  - `op`, mask, dest, SW data;
  - `addr` = `addr_sel` ? `alu_out` : `base_addr`.
- EXEC, LW: `wb_valid`=1, `wb_idx`=dest, `wb_data`=mem[addr]; `done`=1; → IDLE.
- EXEC, SW: mem[addr] ← captured data at end of cycle; `done`=1; → IDLE.
- EXEC, LM/SM: current index = lowest set bit of the remaining mask.
  - LM: `wb_valid`=1, `wb_idx`=index, `wb_data`=mem[addr].
  - SM: `reg_rd_idx`=index; mem[addr] ← `store_data` at end of cycle.
  - At the edge: clear the bit, `addr` ← addr+1.
  - Last set bit: `done`=1 and → IDLE.
- LM/SM with empty mask: exactly one EXEC cycle, no memory access, no `wb_valid`; `done`=1; `next_addr`=start address.
- `next_addr` updates at each transfer edge to transferred address + 1 (wrapping); holds in IDLE.
- Memory read is combinational. A write is visible to any later cycle's read (SM then LM returns the new data).
- Memory contents are not reset.

## Timing
- Reset values: state IDLE; `busy`, `done`, `wb_valid` = 0; `wb_idx`, `wb_data`, `reg_rd_idx`, `next_addr` = 0.
- Outside valid cycles, `wb_idx`/`wb_data` are forced to 0; `reg_rd_idx`=0 outside SM EXEC.
- `start` accepted at edge T: EXEC begins at cycle T+1, `busy`=1 from T+1.
- Latency: max(k,1) EXEC cycles, k = popcount(mask) for LM/SM, k=1 for LW/SW.
- `busy` falls the cycle after `done`. Back-to-back ops are possible with `start` asserted in that cycle.
- `start` while `busy`=1 is ignored; it is not queued.
- Address wrap: 2^ADDR_W−1 + 1 → 0; the memory index wraps mod DEPTH independently.
- `rst_n` low mid-burst: immediate return to IDLE, outputs to reset values. Writes already committed remain; the write of an in-flight SM cycle is discarded.

## Test plan
- SW 0xBEEF to `alu_out`=0x0020 (`addr_sel`=1), then LW `dest_idx`=3 from `base_addr`=0x0020 → `wb_valid` one cycle, `wb_idx`=3, `wb_data`=0xBEEF, `next_addr`=0x0021.
- SM mask 8'b1010_0101 at 0x0010, with `store_data` = 0x1000+`reg_rd_idx` → `reg_rd_idx` 0,2,5,7 on consecutive cycles; mem[0x10..0x13] = 0x1000,0x1002,0x1005,0x1007; 4 busy cycles; `done` on 4th; `next_addr`=0x0014.
- LM same mask/address → `wb_idx` 0,2,5,7 with the data above; no gaps in `wb_valid`.
- LM mask 0 at 0x0040 → one busy cycle, `done`=1, `wb_valid` never high, `next_addr`=0x0040.
- LM mask 8'b0000_0011 at 0xFFFF → reads mem index 0xFF then 0x00; `next_addr`=0x0001.
- `start` pulsed during a 4-transfer SM is ignored. Later, `rst_n` low in 2nd EXEC cycle of an LM → all outputs 0 asynchronously; the next `start` after reset behaves normally.

Source files
------------

// File: rtl/mem_access_seq.sv
// Sequenced memory-access stage: LW/SW single transfers and LM/SM register bursts
// against an internal word-addressed data memory, one transfer per EXEC cycle.
module mem_access_seq #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256,
  parameter int NREG   = 8,
  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic              addr_sel,
  input  logic [NREG-1:0]   reg_mask,
  input  logic [IDX_W-1:0]  dest_idx,
  input  logic [DATA_W-1:0] store_data,
  output logic [IDX_W-1:0]  reg_rd_idx,
  output logic              wb_valid,
  output logic [IDX_W-1:0]  wb_idx,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] next_addr
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] OP_LW = 2'b00;
  localparam logic [1:0] OP_SW = 2'b01;
  localparam logic [1:0] OP_LM = 2'b10;
  localparam logic [1:0] OP_SM = 2'b11;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t              state_r, state_nxt_s;
  logic [1:0]          op_r;
  logic [NREG-1:0]     mask_r;
  logic [IDX_W-1:0]    dest_r;
  logic [DATA_W-1:0]   sw_data_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W-1:0]   next_addr_r;

  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [MEM_AW-1:0]   mem_idx_s;
  logic [DATA_W-1:0]   mem_rdata_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic                mem_we_s;

  logic                mask_empty_s;
  logic                last_s;
  logic                xfer_s;
  logic [IDX_W-1:0]    cur_idx_s;

  // Index of the lowest set bit; zero for an empty mask.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NREG-1:0] m);
    lowest_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (m[i]) begin
        lowest_idx = IDX_W'(i);
      end
    end
  endfunction

  assign mem_idx_s   = addr_r[MEM_AW-1:0];
  assign mem_rdata_s = mem_r[mem_idx_s];
  assign next_addr   = next_addr_r;

  // Decode of the current EXEC cycle: transfer, writeback and memory-write strobes.
  always_comb begin
    mask_empty_s = (mask_r == '0);
    cur_idx_s    = lowest_idx(mask_r);
    state_nxt_s  = state_r;
    last_s       = 1'b0;
    xfer_s       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    wb_valid     = 1'b0;
    wb_idx       = '0;
    wb_data      = '0;
    reg_rd_idx   = '0;
    mem_we_s     = 1'b0;
    mem_wdata_s  = sw_data_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: begin
        busy = 1'b1;
        // A burst ends when at most one bit remains; an empty mask still takes one cycle.
        if (op_r[1]) begin
          last_s = ((mask_r & (mask_r - NREG'(1))) == '0);
          xfer_s = !mask_empty_s;
        end else begin
          last_s = 1'b1;
          xfer_s = 1'b1;
        end
        done = last_s;
        if (last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = EXEC;
        end
        case (op_r)
          OP_LW: begin
            wb_valid = 1'b1;
            wb_idx   = dest_r;
            wb_data  = mem_rdata_s;
          end
          OP_SW: begin
            mem_we_s    = 1'b1;
            mem_wdata_s = sw_data_r;
          end
          OP_LM: begin
            wb_valid = xfer_s;
            if (xfer_s) begin
              wb_idx  = cur_idx_s;
              wb_data = mem_rdata_s;
            end else begin
              wb_idx  = '0;
              wb_data = '0;
            end
          end
          OP_SM: begin
            reg_rd_idx  = cur_idx_s;
            mem_we_s    = xfer_s;
            mem_wdata_s = store_data;
          end
          default: begin
            wb_valid = 1'b0;
          end
        endcase
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Request capture at acceptance, then mask/address walk and base-update tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      op_r        <= OP_LW;
      mask_r      <= '0;
      dest_r      <= '0;
      sw_data_r   <= '0;
      addr_r      <= '0;
      next_addr_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == IDLE) begin
        if (start) begin
          op_r      <= op;
          mask_r    <= reg_mask;
          dest_r    <= dest_idx;
          sw_data_r <= store_data;
          addr_r    <= addr_sel ? alu_out : base_addr;
        end
      end else if (xfer_s) begin
        mask_r      <= mask_r & (mask_r - NREG'(1));
        addr_r      <= addr_r + ADDR_W'(1);
        next_addr_r <= addr_r + ADDR_W'(1);
      end else begin
        next_addr_r <= addr_r;
      end
    end
  end

  // Data memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_idx_s] <= mem_wdata_s;
    end
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// Scoreboard bench for mem_access_seq: stimulus pushes expected writebacks and
// completion records; a negedge monitor pops and compares them.
module tb_mem_access_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] base_addr;
  logic [15:0] alu_out;
  logic        addr_sel;
  logic [7:0]  reg_mask;
  logic [2:0]  dest_idx;
  logic [15:0] store_data;
  logic [2:0]  reg_rd_idx;
  logic        wb_valid;
  logic [2:0]  wb_idx;
  logic [15:0] wb_data;
  logic        busy;
  logic        done;
  logic [15:0] next_addr;

  logic        sm_mode;
  logic [15:0] sw_val;

  int n_vec;
  int n_err;

  logic [18:0] wb_q[$];
  int          done_cyc_q[$];
  logic [15:0] done_na_q[$];

  int          busy_cnt;
  logic        chk_next;
  logic [15:0] exp_na;

  mem_access_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .base_addr  (base_addr),
    .alu_out    (alu_out),
    .addr_sel   (addr_sel),
    .reg_mask   (reg_mask),
    .dest_idx   (dest_idx),
    .store_data (store_data),
    .reg_rd_idx (reg_rd_idx),
    .wb_valid   (wb_valid),
    .wb_idx     (wb_idx),
    .wb_data    (wb_data),
    .busy       (busy),
    .done       (done),
    .next_addr  (next_addr)
  );

  // SM data follows the register the DUT asks for: 0x1000 + index.
  assign store_data = sm_mode ? (16'h1000 + {13'd0, reg_rd_idx}) : sw_val;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: writeback scoreboard, idle-zero outputs, burst length and next_addr.
  initial begin
    busy_cnt = 0;
    chk_next = 1'b0;
    forever begin
      @(negedge clk);
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          check("wb_unexpected", {13'd0, wb_idx, wb_data}, 32'h0);
        end else begin
          check("wb_idx_data", {13'd0, wb_idx, wb_data}, {13'd0, wb_q.pop_front()});
        end
      end else begin
        check("wb_idle_zero", {13'd0, wb_idx, wb_data}, 32'h0);
      end
      if (chk_next) begin
        check("next_addr", {16'd0, next_addr}, {16'd0, exp_na});
        check("busy_after_done", {31'd0, busy}, 32'd0);
        chk_next = 1'b0;
      end
      if (busy) busy_cnt++;
      else busy_cnt = 0;
      if (done) begin
        if (done_cyc_q.size() == 0) begin
          check("done_unexpected", {31'd0, done}, 32'd0);
        end else begin
          check("busy_cycles", busy_cnt, done_cyc_q.pop_front());
          exp_na   = done_na_q.pop_front();
          chk_next = 1'b1;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic sel, input logic [15:0] b,
                       input logic [15:0] a, input logic [7:0] m, input logic [2:0] d,
                       input logic [15:0] sw, input logic smm);
    @(negedge clk);
    op        = o;
    addr_sel  = sel;
    base_addr = b;
    alu_out   = a;
    reg_mask  = m;
    dest_idx  = d;
    sw_val    = sw;
    sm_mode   = smm;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic expect_wb(input logic [2:0] idx, input logic [15:0] data);
    wb_q.push_back({idx, data});
  endtask

  task automatic expect_done(input int cycles, input logic [15:0] na);
    done_cyc_q.push_back(cycles);
    done_na_q.push_back(na);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},       {31'd0, busy},       32'd0);
    check({tag, "_done"},       {31'd0, done},       32'd0);
    check({tag, "_wb_valid"},   {31'd0, wb_valid},   32'd0);
    check({tag, "_wb_idx"},     {29'd0, wb_idx},     32'd0);
    check({tag, "_wb_data"},    {16'd0, wb_data},    32'd0);
    check({tag, "_reg_rd_idx"}, {29'd0, reg_rd_idx}, 32'd0);
    check({tag, "_next_addr"},  {16'd0, next_addr},  32'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    op        = 2'b00;
    base_addr = 16'h0000;
    alu_out   = 16'h0000;
    addr_sel  = 1'b0;
    reg_mask  = 8'h00;
    dest_idx  = 3'd0;
    sw_val    = 16'h0000;
    sm_mode   = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // SW 0xBEEF via alu_out, then LW back via base_addr
    expect_done(1, 16'h0021);
    issue(2'b01, 1'b1, 16'h1234, 16'h0020, 8'h00, 3'd0, 16'hBEEF, 1'b0);
    wait_done();
    expect_wb(3'd3, 16'hBEEF);
    expect_done(1, 16'h0021);
    issue(2'b00, 1'b0, 16'h0020, 16'h5555, 8'h00, 3'd3, 16'h0000, 1'b0);
    wait_done();

    // SM 0xA5 at 0x10 with a start pulse mid-burst that must be ignored
    expect_done(4, 16'h0014);
    issue(2'b11, 1'b0, 16'h0010, 16'h0000, 8'hA5, 3'd0, 16'h0000, 1'b1);
    @(negedge clk);
    op        = 2'b00;
    base_addr = 16'h0020;
    dest_idx  = 3'd6;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // LM of the same set reads back what SM wrote
    expect_wb(3'd0, 16'h1000);
    expect_wb(3'd2, 16'h1002);
    expect_wb(3'd5, 16'h1005);
    expect_wb(3'd7, 16'h1007);
    expect_done(4, 16'h0014);
    issue(2'b10, 1'b0, 16'h0010, 16'h0000, 8'hA5, 3'd0, 16'h0000, 1'b0);
    wait_done();

    // Empty-mask LM: one cycle, no writeback, next_addr = start address
    expect_done(1, 16'h0040);
    issue(2'b10, 1'b1, 16'h0000, 16'h0040, 8'h00, 3'd0, 16'h0000, 1'b0);
    wait_done();

    // Wrap: seed index 0xFF and index 0x00, then LM 0x03 from 0xFFFF
    expect_done(1, 16'h0100);
    issue(2'b01, 1'b0, 16'h00FF, 16'h0000, 8'h00, 3'd0, 16'hAAAA, 1'b0);
    wait_done();
    expect_done(1, 16'h0101);
    issue(2'b01, 1'b0, 16'h0100, 16'h0000, 8'h00, 3'd0, 16'h5555, 1'b0);
    wait_done();
    expect_wb(3'd0, 16'hAAAA);
    expect_wb(3'd1, 16'h5555);
    expect_done(2, 16'h0001);
    issue(2'b10, 1'b0, 16'hFFFF, 16'h0000, 8'h03, 3'd0, 16'h0000, 1'b0);
    wait_done();

    // Asynchronous reset in the 2nd EXEC cycle of an LM
    expect_wb(3'd0, 16'h1000);
    issue(2'b10, 1'b0, 16'h0010, 16'h0000, 8'hA5, 3'd0, 16'h0000, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midburst_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Normal operation after reset; memory contents kept
    expect_wb(3'd5, 16'h1005);
    expect_done(1, 16'h0013);
    issue(2'b00, 1'b0, 16'h0012, 16'h0000, 8'h00, 3'd5, 16'h0000, 1'b0);
    wait_done();

    repeat (3) @(negedge clk);
    check("wb_q_drained",   wb_q.size(),       32'd0);
    check("done_q_drained", done_cyc_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
